mem_store_buffer: RTL and testbench

//  Posted-write store buffer plus load/drain bus sequencer behind the MEM-stage byte-lane logic.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_store_buffer_sb_fifo.sv | 79 +++++++
 rtl/mem_store_buffer.sv | 173 +++++++++++++++++
 tb/tb_mem_store_buffer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage store buffer: entry layout, sequencer states, lane helper.
package mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int SEL_W      = MEM_DATA_W / 8;
  localparam int WADDR_W    = MEM_ADDR_W - 2;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [SEL_W-1:0]   sel;
    logic [MEM_DATA_W-1:0] data;
  } sb_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    LD_ADDR,
    LD_DATA,
    ST_ADDR,
    ST_DATA
  } sb_state_e;

  function automatic logic sel_covers(input logic [SEL_W-1:0] have,
                                      input logic [SEL_W-1:0] need);
    return (have & need) == need;
  endfunction

endpackage

// File: rtl/mem_store_buffer_sb_fifo.sv
// Store-buffer entry storage: in-order FIFO with a parallel word-address compare
// and selection of the youngest matching entry.
module sb_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq,
  input  sb_entry_t                    enq_entry,
  input  logic                         deq,
  input  logic [WADDR_W-1:0]           lookup_waddr,
  output sb_entry_t                    head_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         hit,
  output sb_entry_t                    youngest
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  sb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] hit_vec;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset: valid_q alone decides whether a slot is live.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= enq_entry;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = valid_q[i] & (mem_q[i].waddr == lookup_waddr);
    end
  end

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    youngest = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (hit_vec[idx]) youngest = mem_q[idx];
    end
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;
  assign hit        = |hit_vec;

endmodule

// File: rtl/mem_store_buffer.sv
// Posted-write store buffer and single-outstanding load/drain bus sequencer.
// Optional build macro SB_FORWARD_EN: fully covered cached loads forward from the buffer.
module mem_store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_uncached,
  input  logic              mem_flush,
  output logic              mem_stall,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              sb_empty,
  output logic              data_req,
  output logic              data_wr,
  output logic [ADDR_W-1:0] data_addr,
  output logic [SEL_W-1:0]  data_sel,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  localparam int CNT_W = $clog2(DEPTH+1);

  sb_state_e        state_q, state_d;
  sb_entry_t        head_entry, youngest, enq_entry;
  logic [CNT_W-1:0] count;
  logic             fifo_hit;
  logic             act, st_req, ld_req, full, enq, hit, fwd_ok;
  logic             ld_done, st_done, launch_ld, launch_st;
  logic             ld_squash_q, rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  assign act    = mem_req & ~mem_flush;
  assign st_req = act & mem_wr;
  assign ld_req = act & ~mem_wr;
  assign full   = (count == CNT_W'(DEPTH));
  // A full buffer does not see a same-cycle dequeue; the store retries next cycle.
  assign enq    = st_req & ~full;

  assign enq_entry = '{waddr: mem_addr[ADDR_W-1:2], sel: mem_sel, data: mem_wdata};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .enq          (enq),
    .enq_entry    (enq_entry),
    .deq          (st_done),
    .lookup_waddr (mem_addr[ADDR_W-1:2]),
    .head_entry   (head_entry),
    .count        (count),
    .hit          (fifo_hit),
    .youngest     (youngest)
  );

  assign sb_empty = (count == '0) & (state_q != ST_ADDR) & (state_q != ST_DATA);
  assign hit      = fifo_hit | (mem_uncached & ~sb_empty);

`ifdef SB_FORWARD_EN
  assign fwd_ok    = ld_req & ~mem_uncached & fifo_hit & sel_covers(youngest.sel, mem_sel);
  assign mem_rdata = fwd_ok ? youngest.data : rdata_q;
`else
  logic unused_fwd;
  assign unused_fwd = ^youngest;
  assign fwd_ok     = 1'b0;
  assign mem_rdata  = rdata_q;
`endif

  assign mem_rvalid = (rvalid_q & ld_req) | fwd_ok;
  assign mem_stall  = (st_req & full) | (ld_req & ~mem_rvalid);

  always_comb begin
    state_d   = state_q;
    data_req  = 1'b0;
    ld_done   = 1'b0;
    st_done   = 1'b0;
    launch_ld = 1'b0;
    launch_st = 1'b0;
    case (state_q)
      IDLE: begin
        // rvalid_q marks the hand-back cycle of the load just finished; don't relaunch it.
        if (ld_req & ~hit & ~fwd_ok & ~rvalid_q) begin
          state_d   = LD_ADDR;
          launch_ld = 1'b1;
        end else if (count != '0) begin
          state_d   = ST_ADDR;
          launch_st = 1'b1;
        end
      end
      LD_ADDR: begin
        data_req = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            ld_done = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        if (data_data_ok) begin
          ld_done = 1'b1;
          state_d = IDLE;
        end
      end
      ST_ADDR: begin
        data_req = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            st_done = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (data_data_ok) begin
          st_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_wr     <= 1'b0;
      data_addr   <= '0;
      data_sel    <= '0;
      data_wdata  <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      ld_squash_q <= 1'b0;
    end else begin
      if (launch_ld) begin
        data_wr     <= 1'b0;
        data_addr   <= mem_addr;
        data_sel    <= mem_sel;
        data_wdata  <= '0;
        ld_squash_q <= 1'b0;
      end else if (launch_st) begin
        data_wr    <= 1'b1;
        data_addr  <= {head_entry.waddr, 2'b00};
        data_sel   <= head_entry.sel;
        data_wdata <= head_entry.data;
      end
      // Once the requester flushes or walks away, the in-flight read must not be handed back.
      if (((state_q == LD_ADDR) | (state_q == LD_DATA)) & (mem_flush | ~mem_req))
        ld_squash_q <= 1'b1;
      if (ld_done) rdata_q <= data_rdata;
      rvalid_q <= ld_done & ~ld_squash_q & act;
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Scoreboard bench for mem_store_buffer: architectural memory model, random-latency bus
// responder, write-order and load-data scoreboards, directed corner cases plus random traffic.
module tb_mem_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_wr, mem_uncached, mem_flush;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic        mem_stall, mem_rvalid, sb_empty;
  logic [31:0] mem_rdata;
  logic        data_req, data_wr;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_sel;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  always #5 clk = ~clk;

  mem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_uncached(mem_uncached), .mem_flush(mem_flush),
    .mem_stall(mem_stall), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .sb_empty(sb_empty),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_sel(data_sel),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event expected one", name);
  endtask

  // ---------------- memory models ----------------
  logic [31:0] arch_mem [int unsigned];
  logic [31:0] bus_mem  [int unsigned];

  function automatic logic [31:0] init_word(input int unsigned wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rd_arch(input int unsigned wa);
    return arch_mem.exists(wa) ? arch_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] rd_bus(input int unsigned wa);
    return bus_mem.exists(wa) ? bus_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  typedef struct { logic [31:0] addr; logic [3:0] sel; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] data; logic [3:0] sel; } rd_t;
  wr_t exp_wr_q[$];
  rd_t exp_rd_q[$];

  // ---------------- bus responder + monitor ----------------
  int addr_lat_max = 0, data_lat_max = 0, data_lat_fix = -1;
  bit hold_addr = 0;
  int bus_reads = 0, bus_writes = 0, rvalid_cnt = 0;
  bit bus_busy = 0, armed = 0;
  int a_cnt = 0, d_cnt = 0;
  bit cur_wr;
  logic [31:0] cur_addr, cur_data;
  logic [3:0]  cur_sel;

  task automatic bus_complete();
    data_data_ok = 1'b1;
    if (cur_wr) begin
      bus_mem[cur_addr >> 2] = merge(rd_bus(cur_addr >> 2), cur_data, cur_sel);
      bus_writes++;
    end else begin
      data_rdata = rd_bus(cur_addr >> 2);
      bus_reads++;
    end
    bus_busy = 0;
  endtask

  always @(negedge clk) begin
    int d;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (rst) begin
      bus_busy = 0;
      armed    = 0;
    end else if (bus_busy) begin
      if (d_cnt == 0) bus_complete();
      else d_cnt--;
    end else if (data_req && !hold_addr) begin
      if (!armed) begin
        a_cnt = $urandom_range(addr_lat_max, 0);
        armed = 1;
      end
      if (a_cnt == 0) begin
        armed        = 0;
        data_addr_ok = 1'b1;
        cur_wr   = data_wr;
        cur_addr = data_addr;
        cur_sel  = data_sel;
        cur_data = data_wdata;
        if (data_wr) begin
          if (exp_wr_q.size() == 0) begin
            fail_now("unexpected_bus_write");
          end else begin
            wr_t e;
            e = exp_wr_q.pop_front();
            check("bus_wr_addr", data_addr, e.addr);
            check("bus_wr_sel", data_sel, e.sel);
            check("bus_wr_data", data_wdata, e.data);
          end
        end
        d = (data_lat_fix >= 0) ? data_lat_fix : $urandom_range(data_lat_max, 0);
        if (d == 0) bus_complete();
        else begin
          bus_busy = 1;
          d_cnt    = d - 1;
        end
      end else begin
        a_cnt--;
      end
    end
    #1;
    if (!rst && mem_rvalid) begin
      rvalid_cnt++;
      if (exp_rd_q.size() == 0) begin
        fail_now("unexpected_rvalid");
      end else begin
        rd_t r;
        logic [31:0] mask;
        r = exp_rd_q.pop_front();
`ifdef SB_FORWARD_EN
        for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{r.sel[b]}};
`else
        mask = 32'hFFFF_FFFF;
`endif
        check("load_rdata", mem_rdata & mask, r.data & mask);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    mem_req = 0; mem_wr = 0; mem_addr = '0; mem_sel = '0;
    mem_wdata = '0; mem_uncached = 0; mem_flush = 0;
  endtask

  // Called just after a posedge; returns after the request is accepted.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] data, input bit unc, input bit flush,
                       output int waited);
    bit stalled;
    waited = 0;
    mem_req = 1; mem_wr = wr; mem_addr = addr; mem_sel = sel;
    mem_wdata = data; mem_uncached = unc; mem_flush = flush;
    if (flush) begin
      @(negedge clk); #2;
      check("flush_no_stall", mem_stall, 0);
    end else begin
      if (wr) begin
        exp_wr_q.push_back('{addr: addr, sel: sel, data: data});
        arch_mem[addr >> 2] = merge(rd_arch(addr >> 2), data, sel);
      end else begin
        exp_rd_q.push_back('{data: rd_arch(addr >> 2), sel: sel});
      end
      do begin
        @(negedge clk); #2;
        stalled = mem_stall;
        if (stalled) waited++;
      end while (stalled && waited <= 300);
      if (stalled) fail_now("accept_timeout");
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic wait_empty(input string name);
    int k;
    k = 0;
    while (!(sb_empty && exp_wr_q.size() == 0) && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 500) fail_now(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, rb, k, rv;
    idle_inputs();
    data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_req", data_req, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_rvalid", mem_rvalid, 0);
    check("rst_sb_empty", sb_empty, 1);
    check("rst_data_addr", data_addr, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    rst = 0;
    @(posedge clk); #1;

    // 1: three back-to-back stores on a zero-latency bus
    data_lat_fix = 0;
    rb = bus_writes;
    for (int i = 0; i < 3; i++) begin
      issue(1, 32'h100 + 32'(i * 4), 4'hF, 32'h1111_0000 + 32'(i), 0, 0, w);
      check("t1_no_stall", w, 0);
    end
    wait_empty("t1_drain");
    check("t1_sb_empty", sb_empty, 1);
    check("t1_bus_writes", bus_writes - rb, 3);

    // 2: bus refuses addresses; fifth store must stall while four are buffered
    hold_addr = 1;
    for (int i = 0; i < DEPTH; i++) begin
      issue(1, 32'h180 + 32'(i * 4), 4'(i + 1), $urandom, 0, 0, w);
      check("t2_fill_no_stall", w, 0);
    end
    fork
      issue(1, 32'h1A0, 4'hC, 32'hCAFE_F00D, 0, 0, w);
      begin
        repeat (8) @(negedge clk);
        #2;
        check("t2_full_stall", mem_stall, 1);
        hold_addr = 0;
      end
    join
    check("t2_stalled_long", w >= 8, 1);
    wait_empty("t2_drain");

    // 3: store then load of the same word
    data_lat_fix = -1; addr_lat_max = 1; data_lat_max = 2;
    issue(1, 32'h200, 4'hF, 32'hDEAD_BEEF, 0, 0, w);
    rb = bus_reads;
    issue(0, 32'h200, 4'hF, '0, 0, 0, w);
`ifdef SB_FORWARD_EN
    check("t3_fwd_no_stall", w, 0);
    check("t3_fwd_no_bus_read", bus_reads - rb, 0);
`else
    check("t3_hit_stalls", w > 0, 1);
    check("t3_bus_read", bus_reads - rb, 1);
`endif
    wait_empty("t3_drain");

    // 4: partial-lane store does not satisfy a full-word load
    issue(1, 32'h300, 4'h1, 32'h0000_00A5, 0, 0, w);
    rb = bus_reads;
    issue(0, 32'h300, 4'hF, '0, 0, 0, w);
    check("t4_partial_stalls", w > 0, 1);
    check("t4_bus_read", bus_reads - rb, 1);
    wait_empty("t4_drain");

    // 5: flush a load while its bus read is in flight
    addr_lat_max = 0; data_lat_fix = 3;
    rb = bus_reads; rv = rvalid_cnt;
    mem_req = 1; mem_wr = 0; mem_addr = 32'h400; mem_sel = 4'hF;
    k = 0;
    do begin @(negedge clk); #2; k++; end while (!bus_busy && k < 50);
    if (!bus_busy) fail_now("t5_inflight");
    @(posedge clk); #1;
    mem_flush = 1;
    @(posedge clk); #1;
    idle_inputs();
    k = 0;
    do begin @(negedge clk); #2; k++; end while (bus_busy && k < 50);
    repeat (3) @(posedge clk);
    #1;
    check("t5_bus_read_done", bus_reads - rb, 1);
    check("t5_rvalid_suppressed", rvalid_cnt - rv, 0);

    // 6: reset while a store sits in ST_DATA with another buffered behind it
    data_lat_fix = 20;
    issue(1, 32'h500, 4'hF, 32'h5555_5555, 0, 0, w);
    issue(1, 32'h504, 4'hF, 32'h6666_6666, 0, 0, w);
    k = 0;
    do begin @(negedge clk); #2; k++; end while (!bus_busy && k < 50);
    if (!bus_busy) fail_now("t6_st_data");
    check("t6_not_empty", sb_empty, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    check("t6_rst_data_req", data_req, 0);
    check("t6_rst_sb_empty", sb_empty, 1);
    check("t6_rst_data_addr", data_addr, 0);
    rst = 0;
    exp_wr_q.delete();
    exp_rd_q.delete();
    arch_mem = bus_mem;
    data_lat_fix = -1;
    repeat (4) @(posedge clk);
    #1;
    check("t6_idle_after_rst", data_req, 0);
    check("t6_empty_after_rst", sb_empty, 1);

    // random traffic over a small address window
    addr_lat_max = 2; data_lat_max = 3;
    for (int n = 0; n < 250; n++) begin
      bit wr, unc, fl;
      logic [31:0] a;
      wr  = ($urandom_range(1, 0) == 1);
      unc = ($urandom_range(3, 0) == 0);
      fl  = ($urandom_range(9, 0) == 0);
      a   = 32'h600 + {26'h0, 4'($urandom_range(7, 0)), 2'b00};
      issue(wr, a, 4'($urandom_range(15, 1)), $urandom, unc, fl, w);
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
    end
    wait_empty("rand_drain");
    repeat (10) @(posedge clk);
    #1;
    check("rand_writes_consumed", exp_wr_q.size(), 0);
    check("rand_loads_consumed", exp_rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
